// File: rtl/riscv_zero_decode.sv
// Decode stage of the riscv_zero pipeline: splits RV64I fields, builds sign-extended
// immediates, flags illegal opcodes and registers the result toward execute.
module riscv_zero_decode #(
    parameter int XLEN      = 64,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch_taken,
    input  logic            d_valid,
    output logic            d_ready,
    input  logic [31:0]     d_inst_data,
    input  logic [XLEN-1:0] d_pc,
    input  logic            e_ready,
    output logic            e_valid,
    output logic [XLEN-1:0] e_pc,
    output logic [6:0]      e_opcode,
    output logic [4:0]      e_rd,
    output logic [4:0]      e_rs1,
    output logic [4:0]      e_rs2,
    output logic [2:0]      e_funct3,
    output logic [6:0]      e_funct7,
    output logic [XLEN-1:0] e_imm,
    output logic [2:0]      e_fmt,
    output logic            e_is_load,
    output logic            e_illegal
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            is_load;
        logic            illegal;
    } e_reg_t;

    e_reg_t e_q, e_d, dec;
    logic   ready_q, ready_d;
    fmt_e   fmt;
    logic   uses_rd, uses_rs1, uses_rs2;
    logic   hazard, can_load;

    // Opcode classification; every legal opcode ends in 2'b11, so a bad
    // inst[1:0] can never match and falls through to illegal.
    always_comb begin
        fmt = FMT_ILL;
        case (d_inst_data[6:0])
            7'b0110011, 7'b0111011: fmt = FMT_R;
            7'b0010011, 7'b0011011, 7'b0000011,
            7'b1100111, 7'b1110011, 7'b0001111: fmt = FMT_I;
            7'b0100011: fmt = FMT_S;
            7'b1100011: fmt = FMT_B;
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111: fmt = FMT_J;
            default: fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        uses_rd  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
        uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
        uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

        dec         = '0;
        dec.valid   = 1'b1;
        dec.pc      = d_pc;
        dec.opcode  = d_inst_data[6:0];
        dec.rd      = uses_rd  ? d_inst_data[11:7]  : 5'd0;
        dec.rs1     = uses_rs1 ? d_inst_data[19:15] : 5'd0;
        dec.rs2     = uses_rs2 ? d_inst_data[24:20] : 5'd0;
        dec.funct3  = ((fmt == FMT_U) || (fmt == FMT_J)) ? 3'd0 : d_inst_data[14:12];
        dec.funct7  = (fmt == FMT_R) ? d_inst_data[31:25] : 7'd0;
        dec.fmt     = fmt;
        dec.is_load = (d_inst_data[6:0] == 7'b0000011);
        dec.illegal = (fmt == FMT_ILL);
        case (fmt)
            FMT_I: dec.imm = {{(XLEN-12){d_inst_data[31]}}, d_inst_data[31:20]};
            FMT_S: dec.imm = {{(XLEN-12){d_inst_data[31]}}, d_inst_data[31:25], d_inst_data[11:7]};
            FMT_B: dec.imm = {{(XLEN-13){d_inst_data[31]}}, d_inst_data[31], d_inst_data[7],
                              d_inst_data[30:25], d_inst_data[11:8], 1'b0};
            FMT_U: dec.imm = {{(XLEN-32){d_inst_data[31]}}, d_inst_data[31:12], 12'b0};
            FMT_J: dec.imm = {{(XLEN-21){d_inst_data[31]}}, d_inst_data[31], d_inst_data[19:12],
                              d_inst_data[20], d_inst_data[30:21], 1'b0};
            default: dec.imm = '0;
        endcase
    end

    // Load-use check compares the held load's rd against the raw source fields
    // of the incoming word, qualified by whether its format reads them.
    always_comb begin
        hazard = HAZARD_EN && d_valid && e_q.valid && e_q.is_load && (e_q.rd != 5'd0) &&
                 ((uses_rs1 && (e_q.rd == d_inst_data[19:15])) ||
                  (uses_rs2 && (e_q.rd == d_inst_data[24:20])));
        can_load = !e_q.valid || e_ready;
        d_ready  = ready_q && can_load && !hazard && !branch_taken;
    end

    always_comb begin
        ready_d = 1'b1;
        e_d     = e_q;
        if (branch_taken) begin
            e_d.valid = 1'b0;
        end else if (d_valid && d_ready) begin
            e_d = dec;
        end else if (can_load) begin
            e_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            e_q     <= e_d;
            ready_q <= ready_d;
        end
    end

    assign e_valid   = e_q.valid;
    assign e_pc      = e_q.pc;
    assign e_opcode  = e_q.opcode;
    assign e_rd      = e_q.rd;
    assign e_rs1     = e_q.rs1;
    assign e_rs2     = e_q.rs2;
    assign e_funct3  = e_q.funct3;
    assign e_funct7  = e_q.funct7;
    assign e_imm     = e_q.imm;
    assign e_fmt     = e_q.fmt;
    assign e_is_load = e_q.is_load;
    assign e_illegal = e_q.illegal;

endmodule

// File: tb/tb_riscv_zero_decode.sv
// Self-checking bench for riscv_zero_decode: table vectors, hand-written handshake
// sequences, and randomized traffic against a behavioural model.
module tb_riscv_zero_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken, d_valid, e_ready;
    logic [31:0] d_inst_data;
    logic [63:0] d_pc;
    logic        d_ready, e_valid, e_is_load, e_illegal;
    logic [63:0] e_pc, e_imm;
    logic [6:0]  e_opcode, e_funct7;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [2:0]  e_funct3, e_fmt;

    logic        n_branch_taken, n_d_valid, n_e_ready;
    logic [31:0] n_d_inst_data;
    logic [63:0] n_d_pc;
    logic        n_d_ready, n_e_valid, n_e_is_load, n_e_illegal;
    logic [63:0] n_e_pc, n_e_imm;
    logic [6:0]  n_e_opcode, n_e_funct7;
    logic [4:0]  n_e_rd, n_e_rs1, n_e_rs2;
    logic [2:0]  n_e_funct3, n_e_fmt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_zero_decode #(.XLEN(64), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .branch_taken(branch_taken),
        .d_valid(d_valid), .d_ready(d_ready), .d_inst_data(d_inst_data), .d_pc(d_pc),
        .e_ready(e_ready), .e_valid(e_valid), .e_pc(e_pc), .e_opcode(e_opcode),
        .e_rd(e_rd), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_funct3(e_funct3),
        .e_funct7(e_funct7), .e_imm(e_imm), .e_fmt(e_fmt),
        .e_is_load(e_is_load), .e_illegal(e_illegal)
    );

    riscv_zero_decode #(.XLEN(64), .HAZARD_EN(1'b0)) dut_nh (
        .clk(clk), .reset(reset), .branch_taken(n_branch_taken),
        .d_valid(n_d_valid), .d_ready(n_d_ready), .d_inst_data(n_d_inst_data), .d_pc(n_d_pc),
        .e_ready(n_e_ready), .e_valid(n_e_valid), .e_pc(n_e_pc), .e_opcode(n_e_opcode),
        .e_rd(n_e_rd), .e_rs1(n_e_rs1), .e_rs2(n_e_rs2), .e_funct3(n_e_funct3),
        .e_funct7(n_e_funct7), .e_imm(n_e_imm), .e_fmt(n_e_fmt),
        .e_is_load(n_e_is_load), .e_illegal(n_e_illegal)
    );

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        is_load;
    } ref_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        is_load;
    } vec_t;

    // Reference decoder: immediates come from arithmetic shifts of the
    // sign-extended word rather than bit concatenation.
    function automatic ref_t ref_decode(input logic [31:0] inst);
        ref_t r;
        logic signed [63:0] s;
        r = '0;
        s = {{32{inst[31]}}, inst};
        case (inst[6:0])
            7'h33, 7'h3B: r.fmt = 3'd0;
            7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F: r.fmt = 3'd1;
            7'h23: r.fmt = 3'd2;
            7'h63: r.fmt = 3'd3;
            7'h37, 7'h17: r.fmt = 3'd4;
            7'h6F: r.fmt = 3'd5;
            default: r.fmt = 3'd6;
        endcase
        case (r.fmt)
            3'd1: r.imm = 64'(s >>> 20);
            3'd2: r.imm = 64'((s >>> 25) <<< 5) | 64'(inst[11:7]);
            3'd3: r.imm = 64'((s >>> 31) <<< 12) | (64'(inst[7]) << 11) |
                          (64'(inst[30:25]) << 5) | (64'(inst[11:8]) << 1);
            3'd4: r.imm = 64'(s) & ~64'hFFF;
            3'd5: r.imm = 64'((s >>> 31) <<< 20) | (64'(inst[19:12]) << 12) |
                          (64'(inst[20]) << 11) | (64'(inst[30:21]) << 1);
            default: r.imm = 64'd0;
        endcase
        r.rd      = (r.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) ? inst[11:7] : 5'd0;
        r.rs1     = (r.fmt <= 3'd3) ? inst[19:15] : 5'd0;
        r.rs2     = (r.fmt inside {3'd0, 3'd2, 3'd3}) ? inst[24:20] : 5'd0;
        r.f3      = (r.fmt inside {3'd4, 3'd5}) ? 3'd0 : inst[14:12];
        r.f7      = (r.fmt == 3'd0) ? inst[31:25] : 7'd0;
        r.is_load = (inst[6:0] == 7'h03);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic bt, input logic dv, input logic [31:0] inst,
                                 input logic [63:0] pc, input logic er);
        branch_taken = bt;
        d_valid      = dv;
        d_inst_data  = inst;
        d_pc         = pc;
        e_ready      = er;
    endtask

    task automatic checkHeld(input string tag, input logic [31:0] inst, input logic [63:0] pc);
        ref_t r;
        r = ref_decode(inst);
        checkOutput({tag, "_pc"},      e_pc, pc);
        checkOutput({tag, "_opcode"},  64'(e_opcode), 64'(inst[6:0]));
        checkOutput({tag, "_fmt"},     64'(e_fmt), 64'(r.fmt));
        checkOutput({tag, "_rd"},      64'(e_rd), 64'(r.rd));
        checkOutput({tag, "_rs1"},     64'(e_rs1), 64'(r.rs1));
        checkOutput({tag, "_rs2"},     64'(e_rs2), 64'(r.rs2));
        checkOutput({tag, "_funct3"},  64'(e_funct3), 64'(r.f3));
        checkOutput({tag, "_funct7"},  64'(e_funct7), 64'(r.f7));
        checkOutput({tag, "_imm"},     e_imm, r.imm);
        checkOutput({tag, "_is_load"}, 64'(e_is_load), 64'(r.is_load));
        checkOutput({tag, "_illegal"}, 64'(e_illegal), 64'(r.fmt == 3'd6));
    endtask

    vec_t vecs[$];
    ref_t md, nd;
    logic        m_valid, haz, exp_ready, bt, dv, er;
    logic [31:0] m_inst, inst;
    logic [63:0] m_pc, pc;

    initial begin
        vecs.push_back('{32'h00500093, 64'h100, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd5, 1'b0});
        vecs.push_back('{32'hFE000EE3, 64'h1C,  3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
        vecs.push_back('{32'hFE512C23, 64'h20,  3'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0});
        vecs.push_back('{32'h008000EF, 64'h24,  3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd8, 1'b0});
        vecs.push_back('{32'hFFFFF06F, 64'h28,  3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{32'h002080BB, 64'h2C,  3'd0, 5'd1, 5'd1, 5'd2, 3'd0, 7'h00, 64'd0, 1'b0});
        vecs.push_back('{32'h402081B3, 64'h30,  3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0, 1'b0});
        vecs.push_back('{32'h80000397, 64'h34,  3'd4, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_8000_0000, 1'b0});
        vecs.push_back('{32'h123452B7, 64'h38,  3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_1234_5000, 1'b0});
        vecs.push_back('{32'h00000073, 64'h3C,  3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 1'b0});
        vecs.push_back('{32'hFFF00093, 64'h40,  3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
        vecs.push_back('{32'h00000000, 64'h44,  3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 1'b0});
        vecs.push_back('{32'h00500090, 64'h48,  3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 1'b0});
        vecs.push_back('{32'h0000A103, 64'h4C,  3'd1, 5'd2, 5'd1, 5'd0, 3'd2, 7'h00, 64'd0, 1'b1});

        n_branch_taken = 1'b0; n_d_valid = 1'b0; n_d_inst_data = '0; n_d_pc = '0; n_e_ready = 1'b1;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h00500093, 64'h8, 1'b1);

        // Reset held: nothing visible, nothing accepted.
        repeat (2) @(negedge clk);
        checkOutput("rst_e_valid", 64'(e_valid), 64'd0);
        checkOutput("rst_d_ready", 64'(d_ready), 64'd0);
        checkOutput("rst_e_bus", {e_pc ^ e_imm, 64'(e_opcode)} != '0 ? 64'd1 : 64'd0, 64'd0);
        checkOutput("rst_e_fields", 64'({e_rd, e_rs1, e_rs2, e_funct3, e_funct7, e_fmt, e_is_load, e_illegal}), 64'd0);
        reset = 1'b1;
        #1 checkOutput("rel_d_ready_before_edge", 64'(d_ready), 64'd0);
        @(negedge clk);
        checkOutput("rel_e_valid", 64'(e_valid), 64'd0);
        checkOutput("rel_d_ready", 64'(d_ready), 64'd1);
        @(negedge clk);
        checkOutput("addi_e_valid", 64'(e_valid), 64'd1);
        checkHeld("addi", 32'h00500093, 64'h8);

        // Table of single-instruction decodes, one accept per cycle.
        foreach (vecs[k]) begin
            applyStimulus(1'b0, 1'b1, vecs[k].inst, vecs[k].pc, 1'b1);
            #1 checkOutput($sformatf("tbl%0d_d_ready", k), 64'(d_ready), 64'd1);
            @(negedge clk);
            checkOutput($sformatf("tbl%0d_e_valid", k), 64'(e_valid), 64'd1);
            checkOutput($sformatf("tbl%0d_pc", k), e_pc, vecs[k].pc);
            checkOutput($sformatf("tbl%0d_fmt", k), 64'(e_fmt), 64'(vecs[k].fmt));
            checkOutput($sformatf("tbl%0d_rd", k), 64'(e_rd), 64'(vecs[k].rd));
            checkOutput($sformatf("tbl%0d_rs1", k), 64'(e_rs1), 64'(vecs[k].rs1));
            checkOutput($sformatf("tbl%0d_rs2", k), 64'(e_rs2), 64'(vecs[k].rs2));
            checkOutput($sformatf("tbl%0d_funct3", k), 64'(e_funct3), 64'(vecs[k].f3));
            checkOutput($sformatf("tbl%0d_funct7", k), 64'(e_funct7), 64'(vecs[k].f7));
            checkOutput($sformatf("tbl%0d_imm", k), e_imm, vecs[k].imm);
            checkOutput($sformatf("tbl%0d_is_load", k), 64'(e_is_load), 64'(vecs[k].is_load));
            checkOutput($sformatf("tbl%0d_illegal", k), 64'(e_illegal), 64'(vecs[k].fmt == 3'd6));
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        @(negedge clk);

        // Load-use: lw x2 then add x3,x2,x1 costs one bubble.
        applyStimulus(1'b0, 1'b1, 32'h0000A103, 64'h200, 1'b1);
        #1 checkOutput("lu_lw_d_ready", 64'(d_ready), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h001101B3, 64'h204, 1'b1);
        #1 checkOutput("lu_stall_d_ready", 64'(d_ready), 64'd0);
        checkOutput("lu_lw_held", 64'({e_valid, e_is_load, e_rd}), 64'({1'b1, 1'b1, 5'd2}));
        @(negedge clk);
        checkOutput("lu_bubble_e_valid", 64'(e_valid), 64'd0);
        #1 checkOutput("lu_after_bubble_d_ready", 64'(d_ready), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        checkOutput("lu_add_e_valid", 64'(e_valid), 64'd1);
        checkOutput("lu_add_fields", 64'({e_fmt, e_rd, e_rs1, e_rs2}), 64'({3'd0, 5'd3, 5'd2, 5'd1}));
        checkOutput("lu_add_pc", e_pc, 64'h204);

        // Same pair with hazard detection disabled: no stall, no bubble.
        n_d_valid = 1'b1; n_d_inst_data = 32'h0000A103; n_d_pc = 64'h300;
        #1 checkOutput("nh_lw_d_ready", 64'(n_d_ready), 64'd1);
        @(negedge clk);
        n_d_inst_data = 32'h001101B3; n_d_pc = 64'h304;
        #1 checkOutput("nh_add_d_ready", 64'(n_d_ready), 64'd1);
        checkOutput("nh_lw_held", 64'({n_e_valid, n_e_is_load, n_e_rd}), 64'({1'b1, 1'b1, 5'd2}));
        @(negedge clk);
        n_d_valid = 1'b0;
        checkOutput("nh_add_e_valid", 64'(n_e_valid), 64'd1);
        checkOutput("nh_add_fields", 64'({n_e_fmt, n_e_rs1, n_e_rs2}), 64'({3'd0, 5'd2, 5'd1}));
        checkOutput("nh_add_pc", n_e_pc, 64'h304);

        // lui held under backpressure, then drained.
        applyStimulus(1'b0, 1'b1, 32'h123452B7, 64'h400, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h00500093, 64'h404, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1 checkOutput($sformatf("bp%0d_d_ready", c), 64'(d_ready), 64'd0);
            checkOutput($sformatf("bp%0d_e_valid", c), 64'(e_valid), 64'd1);
            checkOutput($sformatf("bp%0d_imm", c), e_imm, 64'h0000_0000_1234_5000);
            checkOutput($sformatf("bp%0d_rd_pc", c), e_pc + 64'(e_rd), 64'h405);
            @(negedge clk);
        end
        e_ready = 1'b1;
        #1 checkOutput("bp_release_d_ready", 64'(d_ready), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        checkHeld("bp_next", 32'h00500093, 64'h404);

        // Illegal word, then a flush drops both held and incoming.
        applyStimulus(1'b0, 1'b1, 32'h00000000, 64'h500, 1'b1);
        @(negedge clk);
        checkOutput("ill_e_valid", 64'(e_valid), 64'd1);
        checkOutput("ill_flags", 64'({e_illegal, e_fmt}), 64'({1'b1, 3'd6}));
        applyStimulus(1'b1, 1'b1, 32'h00500093, 64'h504, 1'b1);
        #1 checkOutput("flush_d_ready", 64'(d_ready), 64'd0);
        @(negedge clk);
        checkOutput("flush_e_valid", 64'(e_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        @(negedge clk);
        checkOutput("flush_dropped_e_valid", 64'(e_valid), 64'd0);

        // Reset mid-stream discards the held instruction immediately.
        applyStimulus(1'b0, 1'b1, 32'h00500093, 64'h600, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
        reset = 1'b0;
        #1 checkOutput("midrst_e_valid", 64'(e_valid), 64'd0);
        checkOutput("midrst_e_imm", e_imm, 64'd0);
        checkOutput("midrst_d_ready", 64'(d_ready), 64'd0);
        #1 reset = 1'b1;
        @(posedge clk);
        m_valid = 1'b0; m_inst = '0; m_pc = '0;

        // Randomized traffic against the behavioural model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            checkOutput("rnd_e_valid", 64'(e_valid), 64'(m_valid));
            if (m_valid) checkHeld("rnd", m_inst, m_pc);
            bt   = ($urandom_range(0, 15) == 0);
            dv   = ($urandom_range(0, 3) != 0);
            er   = ($urandom_range(0, 3) != 0);
            inst = $urandom;
            case ($urandom_range(0, 15))
                0: inst[6:0] = 7'h33;  1: inst[6:0] = 7'h3B;  2: inst[6:0] = 7'h13;
                3: inst[6:0] = 7'h1B;  4, 5: inst[6:0] = 7'h03; 6: inst[6:0] = 7'h67;
                7: inst[6:0] = 7'h73;  8: inst[6:0] = 7'h0F;  9: inst[6:0] = 7'h23;
                10: inst[6:0] = 7'h63; 11: inst[6:0] = 7'h37; 12: inst[6:0] = 7'h17;
                13: inst[6:0] = 7'h6F; default: inst[6:0] = 7'(inst[6:0]);
            endcase
            inst[11:7]  = 5'($urandom_range(0, 3));
            inst[19:15] = 5'($urandom_range(0, 3));
            inst[24:20] = 5'($urandom_range(0, 3));
            pc = {$urandom, $urandom};
            applyStimulus(bt, dv, inst, pc, er);
            #1;
            md  = ref_decode(m_inst);
            nd  = ref_decode(inst);
            haz = dv && m_valid && md.is_load && (md.rd != 5'd0) &&
                  (((nd.fmt <= 3'd3) && (md.rd == inst[19:15])) ||
                   ((nd.fmt inside {3'd0, 3'd2, 3'd3}) && (md.rd == inst[24:20])));
            exp_ready = (!m_valid || er) && !haz && !bt;
            checkOutput("rnd_d_ready", 64'(d_ready), 64'(exp_ready));
            if (bt) begin
                m_valid = 1'b0;
            end else if (dv && exp_ready) begin
                m_valid = 1'b1;
                m_inst  = inst;
                m_pc    = pc;
            end else if (!m_valid || er) begin
                m_valid = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
